// File: rtl/minesweeper_pkg.sv
// ============================================================================
// minesweeper_pkg: board geometry, game-state encodings and cell indexing.
// Revision: 1.0
// ============================================================================
`default_nettype none

package minesweeper_pkg;

  localparam int BOARD_DIM = 8;
  localparam int NUM_CELLS = BOARD_DIM * BOARD_DIM;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_GEN  = 3'd1,
    ST_PLAY = 3'd2,
    ST_LOST = 3'd3,
    ST_WON  = 3'd4
  } game_state_t;

  // Flat cell index 8*x+y; with an 8x8 board this is just {x, y}.
  function automatic logic [5:0] idx(input logic [2:0] x, input logic [2:0] y);
    return {x, y};
  endfunction

endpackage

`default_nettype wire

// File: rtl/mine_lfsr.sv
// ============================================================================
// mine_lfsr: free-running 16-bit Fibonacci LFSR (taps 16,14,13,11).
// Revision: 1.0
// ============================================================================
`default_nettype none

module mine_lfsr (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] seed,
  output logic [15:0] lfsr_out
);

  logic [15:0] r_lfsr;
  logic        w_fb;

  assign w_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lfsr <= seed;
    end else begin
      r_lfsr <= {r_lfsr[14:0], w_fb};
    end
  end

  assign lfsr_out = r_lfsr;

endmodule

`default_nettype wire

// File: rtl/game_controller.sv
// ============================================================================
// game_controller: Minesweeper round sequencer - mine placement, win/loss
// detection and cursor neighbourhood mine count.  Revision: 1.0
// ============================================================================
`default_nettype none

module game_controller
  import minesweeper_pkg::*;
#(
  parameter int          NUM_MINES = 10,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 btn_start,
  input  logic [NUM_CELLS-1:0] clicked_flat,
  input  logic [5:0]           num_clicked,
  input  logic [2:0]           cursor_X,
  input  logic [2:0]           cursor_Y,
  output logic                 load_new_map,
  output logic [NUM_CELLS-1:0] mine_flat,
  output logic [2:0]           game_state,
  output logic                 cursor_mine,
  output logic [3:0]           cursor_adj
);

  localparam logic [5:0] C_MINE_TARGET = 6'(NUM_MINES);
  localparam logic [5:0] C_WIN_CLICKS  = 6'(64 - NUM_MINES);
  localparam logic [2:0] C_EDGE        = 3'(BOARD_DIM - 1);

  game_state_t          r_state;
  game_state_t          w_state_nxt;
  logic [NUM_CELLS-1:0] r_mine_flat;
  logic [NUM_CELLS-1:0] w_mine_nxt;
  logic [5:0]           r_mine_cnt;
  logic [5:0]           w_cnt_nxt;
  logic                 r_load;
  logic [NUM_CELLS-1:0] r_clicked;
  logic [5:0]           r_num_clicked;
  logic                 r_cursor_mine;
  logic [3:0]           r_cursor_adj;
  logic [15:0]          w_lfsr;
  logic [5:0]           w_gen_idx;
  logic                 w_restart;
  logic                 w_unused_lfsr;

  mine_lfsr u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .seed     (LFSR_SEED),
    .lfsr_out (w_lfsr)
  );

  assign w_gen_idx     = w_lfsr[5:0];
  assign w_unused_lfsr = ^w_lfsr[15:6];

  always_comb begin
    w_state_nxt = r_state;
    w_mine_nxt  = r_mine_flat;
    w_cnt_nxt   = r_mine_cnt;
    w_restart   = 1'b0;
    unique case (r_state)
      ST_IDLE: w_restart = btn_start;
      ST_GEN: begin
        // A position already holding a mine burns the cycle; no duplicates.
        if (!r_mine_flat[w_gen_idx]) begin
          w_mine_nxt[w_gen_idx] = 1'b1;
          w_cnt_nxt             = r_mine_cnt + 6'd1;
          if (w_cnt_nxt == C_MINE_TARGET) w_state_nxt = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (btn_start)                       w_restart   = 1'b1;
        else if (|(r_clicked & r_mine_flat)) w_state_nxt = ST_LOST;
        else if (r_num_clicked == C_WIN_CLICKS) w_state_nxt = ST_WON;
      end
      ST_LOST, ST_WON: w_restart = btn_start;
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_restart) begin
      w_state_nxt = ST_GEN;
      w_mine_nxt  = '0;
      w_cnt_nxt   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_mine_flat   <= '0;
      r_mine_cnt    <= '0;
      r_load        <= 1'b1;
      r_clicked     <= '0;
      r_num_clicked <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_mine_flat   <= w_mine_nxt;
      r_mine_cnt    <= w_cnt_nxt;
      r_load        <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_GEN);
      r_clicked     <= clicked_flat;
      r_num_clicked <= num_clicked;
    end
  end

  // Neighbour lookup: off-board neighbours are gated to zero, never wrapped.
  logic       w_xlo, w_xhi, w_ylo, w_yhi;
  logic [2:0] w_xm, w_xp, w_ym, w_yp;
  logic [7:0] w_nb;
  logic [3:0] w_adj;

  assign w_xlo = (cursor_X != 3'd0);
  assign w_xhi = (cursor_X != C_EDGE);
  assign w_ylo = (cursor_Y != 3'd0);
  assign w_yhi = (cursor_Y != C_EDGE);
  assign w_xm  = cursor_X - 3'd1;
  assign w_xp  = cursor_X + 3'd1;
  assign w_ym  = cursor_Y - 3'd1;
  assign w_yp  = cursor_Y + 3'd1;

  assign w_nb[0] = w_xlo & w_ylo & r_mine_flat[idx(w_xm, w_ym)];
  assign w_nb[1] = w_xlo &         r_mine_flat[idx(w_xm, cursor_Y)];
  assign w_nb[2] = w_xlo & w_yhi & r_mine_flat[idx(w_xm, w_yp)];
  assign w_nb[3] =         w_ylo & r_mine_flat[idx(cursor_X, w_ym)];
  assign w_nb[4] =         w_yhi & r_mine_flat[idx(cursor_X, w_yp)];
  assign w_nb[5] = w_xhi & w_ylo & r_mine_flat[idx(w_xp, w_ym)];
  assign w_nb[6] = w_xhi &         r_mine_flat[idx(w_xp, cursor_Y)];
  assign w_nb[7] = w_xhi & w_yhi & r_mine_flat[idx(w_xp, w_yp)];

  assign w_adj = 4'(w_nb[0]) + 4'(w_nb[1]) + 4'(w_nb[2]) + 4'(w_nb[3])
               + 4'(w_nb[4]) + 4'(w_nb[5]) + 4'(w_nb[6]) + 4'(w_nb[7]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cursor_mine <= 1'b0;
      r_cursor_adj  <= '0;
    end else begin
      r_cursor_mine <= r_mine_flat[idx(cursor_X, cursor_Y)];
      r_cursor_adj  <= w_adj;
    end
  end

  assign load_new_map = r_load;
  assign mine_flat    = r_mine_flat;
  assign game_state   = r_state;
  assign cursor_mine  = r_cursor_mine;
  assign cursor_adj   = r_cursor_adj;

endmodule

`default_nettype wire

// File: tb/tb_game_controller.sv
// ============================================================================
// tb_game_controller: randomized rounds checked every cycle against a
// behavioural game model.  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_game_controller;

  localparam int NUM_MINES = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        btn_start;
  logic [63:0] clicked_flat;
  logic [5:0]  num_clicked;
  logic [2:0]  cursor_X, cursor_Y;
  logic        load_new_map;
  logic [63:0] mine_flat;
  logic [2:0]  game_state;
  logic        cursor_mine;
  logic [3:0]  cursor_adj;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  game_controller #(.NUM_MINES(NUM_MINES), .LFSR_SEED(16'hACE1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_start    (btn_start),
    .clicked_flat (clicked_flat),
    .num_clicked  (num_clicked),
    .cursor_X     (cursor_X),
    .cursor_Y     (cursor_Y),
    .load_new_map (load_new_map),
    .mine_flat    (mine_flat),
    .game_state   (game_state),
    .cursor_mine  (cursor_mine),
    .cursor_adj   (cursor_adj)
  );

  always #5 clk = ~clk;

  // Behavioural model state (0 IDLE, 1 GEN, 2 PLAY, 3 LOST, 4 WON)
  int          m_state, m_cnt, m_nreg, m_cadj;
  logic [63:0] m_mines, m_creg;
  logic [15:0] m_lfsr;
  logic        m_load, m_cmine;

  function automatic logic [15:0] lstep(input logic [15:0] l);
    return {l[14:0], ^(l & 16'hB400)};
  endfunction

  function automatic int adj_count(input logic [63:0] mines, input int x, input int y);
    int n;
    n = 0;
    for (int dx = -1; dx <= 1; dx++)
      for (int dy = -1; dy <= 1; dy++)
        if ((dx != 0 || dy != 0) && x + dx >= 0 && x + dx < 8 &&
            y + dy >= 0 && y + dy < 8 && mines[8 * (x + dx) + (y + dy)])
          n++;
    return n;
  endfunction

  task automatic model_step();
    int          ns, nc, ci;
    logic [63:0] nm;
    if (!rst_n) begin
      m_state = 0; m_load = 1'b1; m_mines = '0; m_cnt = 0;
      m_cmine = 1'b0; m_cadj = 0; m_lfsr = 16'hACE1; m_creg = '0; m_nreg = 0;
    end else begin
      ns = m_state; nm = m_mines; nc = m_cnt;
      case (m_state)
        1: begin
          ci = int'(m_lfsr % 64);
          if (!m_mines[ci]) begin
            nm[ci] = 1'b1;
            nc++;
            if (nc == NUM_MINES) ns = 2;
          end
        end
        2: begin
          if (btn_start) begin ns = 1; nm = '0; nc = 0; end
          else if ((m_creg & m_mines) != 0) ns = 3;
          else if (m_nreg == 64 - NUM_MINES) ns = 4;
        end
        default: if (btn_start) begin ns = 1; nm = '0; nc = 0; end
      endcase
      m_cmine = m_mines[8 * cursor_X + cursor_Y];
      m_cadj  = adj_count(m_mines, cursor_X, cursor_Y);
      m_state = ns; m_mines = nm; m_cnt = nc;
      m_load  = (ns == 0 || ns == 1);
      m_creg  = clicked_flat;
      m_nreg  = num_clicked;
      m_lfsr  = lstep(m_lfsr);
    end
  endtask

  always @(posedge clk) model_step();

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("game_state",   64'(game_state),   64'(m_state));
      check("load_new_map", 64'(load_new_map), 64'(m_load));
      check("mine_flat",    mine_flat,         m_mines);
      check("cursor_mine",  64'(cursor_mine),  64'(m_cmine));
      check("cursor_adj",   64'(cursor_adj),   64'(m_cadj));
    end
  end

  task automatic cyc();
    @(negedge clk);
    cursor_X = 3'($urandom_range(0, 7));
    cursor_Y = 3'($urandom_range(0, 7));
  endtask

  function automatic logic [63:0] pick_mine();
    int s;
    s = $urandom_range(0, 63);
    for (int i = 0; i < 64; i++)
      if (m_mines[(s + i) % 64]) return 64'd1 << ((s + i) % 64);
    return '0;
  endfunction

  function automatic logic [63:0] safe_clicks();
    return {$urandom, $urandom} & ~m_mines;
  endfunction

  task automatic start_round(input string tag);
    clicked_flat = '0; num_clicked = '0; btn_start = 1'b1;
    cyc();
    btn_start = 1'b0;
    check({tag, "_gen_entry"}, 64'(game_state), 64'd1);
    check({tag, "_gen_clear"}, mine_flat, 64'd0);
  endtask

  task automatic wait_play(input string tag);
    int k;
    k = 0;
    while (game_state !== 3'd2 && k < 3000) begin
      btn_start = ($urandom_range(0, 3) == 0);
      cyc();
      k++;
    end
    btn_start = 1'b0;
    check({tag, "_reach_play"}, 64'(game_state), 64'd2);
    check({tag, "_load_low"}, 64'(load_new_map), 64'd0);
    check({tag, "_mine_count"}, 64'($countones(mine_flat)), 64'(NUM_MINES));
  endtask

  task automatic play_safe(input int n);
    for (int i = 0; i < n; i++) begin
      clicked_flat = safe_clicks();
      num_clicked  = 6'($urandom_range(0, 53));
      cyc();
    end
  endtask

  logic [63:0] saved;
  logic [63:0] pin_map;

  initial begin
    rst_n = 1'b0; btn_start = 1'b0; clicked_flat = '0; num_clicked = '0;
    cursor_X = '0; cursor_Y = '0;
    cyc();
    chk_en = 1'b1;
    cyc();
    check("rst_state", 64'(game_state), 64'd0);
    check("rst_load", 64'(load_new_map), 64'd1);
    check("rst_mines", mine_flat, 64'd0);
    check("rst_adj", 64'(cursor_adj), 64'd0);

    pin_map = (64'd1 << 1) | (64'd1 << 8) | (64'd1 << 9);
    check("model_adj_corner", 64'(adj_count(pin_map, 0, 0)), 64'd3);
    check("model_adj_nowrap", 64'(adj_count(pin_map, 7, 7)), 64'd0);

    rst_n = 1'b1;
    repeat ($urandom_range(1, 20)) cyc();

    for (int r = 0; r < 5; r++) begin
      start_round($sformatf("r%0d", r));
      wait_play($sformatf("r%0d", r));
      play_safe($urandom_range(3, 12));
      saved = m_mines;
      case (r)
        0: begin
          clicked_flat = pick_mine(); num_clicked = 6'd20;
          cyc();
          check("hit_latency", 64'(game_state), 64'd2);
          cyc();
          check("hit_lost", 64'(game_state), 64'd3);
          check("hit_mines_held", mine_flat, saved);
        end
        1, 4: begin
          clicked_flat = safe_clicks(); num_clicked = 6'd54;
          cyc(); cyc();
          check("win", 64'(game_state), 64'd4);
          num_clicked = 6'd0;
          repeat (3) cyc();
          check("win_hold", 64'(game_state), 64'd4);
        end
        2: begin
          clicked_flat = pick_mine(); num_clicked = 6'd54;
          cyc(); cyc();
          check("hit_and_win_lost", 64'(game_state), 64'd3);
        end
        default: begin
          clicked_flat = pick_mine();
          cyc();
          btn_start = 1'b1;
          cyc();
          btn_start = 1'b0; clicked_flat = '0;
          check("restart_prio", 64'(game_state), 64'd1);
          wait_play("r3b");
          rst_n = 1'b0;
          cyc();
          rst_n = 1'b1;
          check("rst_mid_play", 64'(game_state), 64'd0);
          cyc();
        end
      endcase
    end

    start_round("gen_rst");
    repeat (3) cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    check("rst_mid_gen_state", 64'(game_state), 64'd0);
    check("rst_mid_gen_load", 64'(load_new_map), 64'd1);
    check("rst_mid_gen_mines", mine_flat, 64'd0);
    repeat (5) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
